// File: rtl/alu_issue_wb.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_wb
// Purpose  : Operand-issue and writeback stage wrapped around an external,
//            purely combinational ALU. Owns the architectural register file,
//            accepts one instruction per cycle over valid/ready, resolves
//            operands with full forwarding, drives the ALU from the issue
//            register (S1) and captures its result in the result register
//            (S2). The result is written back when the consumer takes it.
//
// Ports    : clk, reset              clock, synchronous active-high reset
//            in_valid / in_ready     instruction handshake
//            in_fn, in_rs1, in_rs2,  instruction fields (fn is not decoded)
//            in_rd, in_we,
//            in_use_imm, in_imm
//            alu_a, alu_b, alu_fn    operands/function to the external alu
//            alu_r, alu_z            result/zero flag from the external alu
//            out_valid / out_ready   result handshake
//            out_result, out_zero,   captured result, zero flag, destination
//            out_rd
//
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_wb #(
    parameter int N    = 32,
    parameter int NREG = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_fn,
    input  logic [$clog2(NREG)-1:0]  in_rs1,
    input  logic [$clog2(NREG)-1:0]  in_rs2,
    input  logic [$clog2(NREG)-1:0]  in_rd,
    input  logic                     in_we,
    input  logic                     in_use_imm,
    input  logic [N-1:0]             in_imm,
    output logic [N-1:0]             alu_a,
    output logic [N-1:0]             alu_b,
    output logic [4:0]               alu_fn,
    input  logic [N-1:0]             alu_r,
    input  logic                     alu_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_result,
    output logic                     out_zero,
    output logic [$clog2(NREG)-1:0]  out_rd
);

    localparam int AW = $clog2(NREG);

    // Architectural register file; entry 0 is never written.
    logic [N-1:0]  r_rf [NREG];

    // S1: issue register, feeds the alu directly.
    logic          r_s1_valid;
    logic [4:0]    r_s1_fn;
    logic [AW-1:0] r_s1_rd;
    logic          r_s1_we;
    logic [N-1:0]  r_s1_a;
    logic [N-1:0]  r_s1_b;

    // S2: result register, feeds the output port.
    logic          r_s2_valid;
    logic [N-1:0]  r_s2_result;
    logic          r_s2_zero;
    logic [AW-1:0] r_s2_rd;
    logic          r_s2_we;

    logic          w_s2_adv;
    logic          w_s1_adv;
    logic          w_s2_fire;
    logic          w_accept;
    logic [N-1:0]  w_op_a;
    logic [N-1:0]  w_op_b;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_adv;
    assign w_s2_fire = r_s2_valid && out_ready;
    assign in_ready  = !reset && (!r_s1_valid || w_s2_adv);
    assign w_accept  = in_valid && in_ready;

    // Youngest producer wins. A matching S1 that cannot advance blocks
    // in_ready, so when an accept happens a matching S1 is always advancing
    // and its value is the live alu output. S2 holds the value that is
    // either being written this edge or still waiting to be written.
    function automatic logic [N-1:0] f_resolve(input logic [AW-1:0] rs);
        logic [N-1:0] v;
        if (rs == '0)
            v = '0;
        else if (r_s1_valid && r_s1_we && (r_s1_rd == rs))
            v = alu_r;
        else if (r_s2_valid && r_s2_we && (r_s2_rd == rs))
            v = r_s2_result;
        else
            v = r_rf[rs];
        return v;
    endfunction

    assign w_op_a = f_resolve(in_rs1);
    assign w_op_b = in_use_imm ? in_imm : f_resolve(in_rs2);

    // S1 stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_fn    <= '0;
            r_s1_rd    <= '0;
            r_s1_we    <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_fn    <= in_fn;
            r_s1_rd    <= in_rd;
            r_s1_we    <= in_we;
            r_s1_a     <= w_op_a;
            r_s1_b     <= w_op_b;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2 stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_zero   <= 1'b0;
            r_s2_rd     <= '0;
            r_s2_we     <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid  <= 1'b1;
            r_s2_result <= alu_r;
            r_s2_zero   <= alu_z;
            r_s2_rd     <= r_s1_rd;
            r_s2_we     <= r_s1_we;
        end else if (w_s2_fire) begin
            r_s2_valid  <= 1'b0;
        end
    end

    // Writeback happens only when the consumer takes the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf <= '{default: '0};
        end else if (w_s2_fire && r_s2_we && (r_s2_rd != '0)) begin
            r_rf[r_s2_rd] <= r_s2_result;
        end
    end

    assign alu_a      = r_s1_a;
    assign alu_b      = r_s1_b;
    assign alu_fn     = r_s1_fn;
    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_zero   = r_s2_zero;
    assign out_rd     = r_s2_rd;

endmodule
`default_nettype wire
